// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: FSM state encoding and the default fill byte.
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from pointers carrying one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = pop_i && !w_empty;
  // A push while full is accepted only when the head leaves in the same cycle.
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds the SPI byte engine a multi-byte transaction from a TX FIFO and collects received bytes
// into an RX FIFO, signalling completion once the engine releases chip-select.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int         TX_DEPTH  = 16,
  parameter int         RX_DEPTH  = 16,
  parameter int         LEN_W     = 8,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tx_underrun_o,
  output logic             rx_overflow_o,
  output logic             spi_en_o,
  output logic [7:0]       spi_mosi_data_o,
  input  logic [7:0]       spi_miso_data_i,
  input  logic             spi_data_ready_i,
  input  logic             spi_cs_i
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] w_remaining_next;
  logic [7:0]       r_mosi;
  logic [7:0]       w_mosi_next;
  logic             r_en;
  logic             w_en_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_underrun;
  logic             w_underrun_next;
  logic             r_overflow;
  logic             w_overflow_next;

  logic             w_tx_full;
  logic             w_tx_empty;
  logic [7:0]       w_tx_head;
  logic             w_tx_push_req;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_tx_bypass;
  logic             w_take;
  logic [7:0]       w_next_byte;
  logic             w_underrun_hit;

  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_rx_drop;

  assign w_tx_push_req = tx_valid_i && !w_tx_full;

  // A new MOSI byte is needed in LOAD and on every engine handshake except the last one.
  assign w_take = (r_state == S_LOAD) ||
                  ((r_state == S_RUN) && spi_data_ready_i && (r_remaining != LEN_ONE));

  // With the TX FIFO empty, a byte arriving in the same cycle goes straight to the engine.
  assign w_tx_bypass    = w_take && w_tx_empty && w_tx_push_req;
  assign w_tx_push      = w_tx_push_req && !w_tx_bypass;
  assign w_tx_pop       = w_take && !w_tx_empty;
  assign w_underrun_hit = w_take && w_tx_empty && !w_tx_push_req;
  assign w_next_byte    = !w_tx_empty   ? w_tx_head :
                          w_tx_push_req ? tx_data_i : FILL_BYTE;

  assign w_rx_push = (r_state == S_RUN) && spi_data_ready_i;
  assign w_rx_pop  = rx_ready_i && !w_rx_empty;
  assign w_rx_drop = w_rx_push && w_rx_full && !w_rx_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_tx_push),
    .data_i  (tx_data_i),
    .pop_i   (w_tx_pop),
    .data_o  (w_tx_head),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_rx_push),
    .data_i  (spi_miso_data_i),
    .pop_i   (w_rx_pop),
    .data_o  (rx_data_o),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_mosi      <= 8'h00;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_mosi      <= w_mosi_next;
      r_en        <= w_en_next;
      r_done      <= w_done_next;
      r_underrun  <= w_underrun_next;
      r_overflow  <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_mosi_next      = r_mosi;
    w_en_next        = r_en;
    w_done_next      = 1'b0;
    w_underrun_next  = r_underrun;
    w_overflow_next  = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) begin
          w_remaining_next = len_i;
          w_underrun_next  = 1'b0;
          w_overflow_next  = 1'b0;
          w_state_next     = S_LOAD;
        end
      end
      S_LOAD: begin
        w_mosi_next  = w_next_byte;
        w_en_next    = 1'b1;
        w_state_next = S_RUN;
        if (w_underrun_hit) w_underrun_next = 1'b1;
      end
      S_RUN: begin
        if (spi_data_ready_i) begin
          w_remaining_next = r_remaining - LEN_ONE;
          // Dropping en here lets the engine close chip-select after the byte in flight.
          if (r_remaining == LEN_ONE) begin
            w_en_next    = 1'b0;
            w_state_next = S_DRAIN;
          end else begin
            w_mosi_next = w_next_byte;
            if (w_underrun_hit) w_underrun_next = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (spi_cs_i) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_rx_drop) w_overflow_next = 1'b1;
  end

  assign tx_ready_o      = !w_tx_full;
  assign rx_valid_o      = !w_rx_empty;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign tx_underrun_o   = r_underrun;
  assign rx_overflow_o   = r_overflow;
  assign spi_en_o        = r_en;
  assign spi_mosi_data_o = r_mosi;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer driving a behavioural SPI byte engine in MOSI->MISO loopback.
module tb_spi_byte_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       start_i;
  logic [7:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic       tx_underrun_o;
  logic       rx_overflow_o;
  logic       spi_en_o;
  logic [7:0] spi_mosi_data_o;
  logic [7:0] engMiso;
  logic       engReady;
  logic       engCs;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int doneCount      = 0;
  int csRiseCount    = 0;
  logic csPrev       = 1'b1;

  logic [7:0] sentQ[$];
  logic [7:0] rxQ[$];

  logic       engActive;
  int         engCnt;
  logic [7:0] engShift;

  spi_byte_sequencer #(
    .TX_DEPTH  (16),
    .RX_DEPTH  (2),
    .LEN_W     (8),
    .FILL_BYTE (8'hFF)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .tx_data_i        (tx_data_i),
    .tx_valid_i       (tx_valid_i),
    .tx_ready_o       (tx_ready_o),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready_i),
    .start_i          (start_i),
    .len_i            (len_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .tx_underrun_o    (tx_underrun_o),
    .rx_overflow_o    (rx_overflow_o),
    .spi_en_o         (spi_en_o),
    .spi_mosi_data_o  (spi_mosi_data_o),
    .spi_miso_data_i  (engMiso),
    .spi_data_ready_i (engReady),
    .spi_cs_i         (engCs)
  );

  always #5 clk_i = ~clk_i;

  // Engine model, clock divider 4: 32 cycles per byte, ready pulse, then en/mosi sampled two cycles later.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      engActive <= 1'b0;
      engCnt    <= 0;
      engShift  <= 8'h00;
      engCs     <= 1'b1;
      engReady  <= 1'b0;
      engMiso   <= 8'h00;
    end else begin
      engReady <= 1'b0;
      if (!engActive) begin
        if (spi_en_o) begin
          engActive <= 1'b1;
          engCs     <= 1'b0;
          engShift  <= spi_mosi_data_o;
          engCnt    <= 0;
          sentQ.push_back(spi_mosi_data_o);
        end
      end else begin
        engCnt <= engCnt + 1;
        if (engCnt == 31) begin
          engReady <= 1'b1;
          engMiso  <= engShift;
        end
        if (engCnt == 33) begin
          if (spi_en_o) begin
            engShift <= spi_mosi_data_o;
            engCnt   <= 0;
            sentQ.push_back(spi_mosi_data_o);
          end else begin
            engCs     <= 1'b1;
            engActive <= 1'b0;
          end
        end
      end
    end
  end

  // Host side RX consumer and event monitors.
  always @(posedge clk_i) begin
    if (!rst_i && rx_valid_o && rx_ready_i) rxQ.push_back(rx_data_o);
  end

  always @(negedge clk_i) begin
    if (done_o) doneCount++;
    if (engCs && !csPrev) csRiseCount++;
    csPrev = engCs;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBytes(input string tag, input logic [7:0] got[$], input logic [63:0] packedExp,
                            input int n);
    checkOutput($sformatf("%s.count", tag), got.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), got[i], packedExp[(n-1-i)*8 +: 8]);
    end
  endtask

  task automatic pushTx(input logic [7:0] b);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] len);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 3000 && busy_o; i++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
    checkOutput({tag, ".idle"}, busy_o, 0);
  endtask

  initial begin
    int doneBase;
    int csBase;
    logic sawBusy;

    rst_i      = 1'b1;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b1;
    start_i    = 1'b0;
    len_i      = 8'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset asserted while idle
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst.busy", busy_o, 0);
    checkOutput("rst.done", done_o, 0);
    checkOutput("rst.en", spi_en_o, 0);
    checkOutput("rst.mosi", spi_mosi_data_o, 8'h00);
    checkOutput("rst.underrun", tx_underrun_o, 0);
    checkOutput("rst.overflow", rx_overflow_o, 0);
    checkOutput("rst.txReady", tx_ready_o, 1);
    checkOutput("rst.rxValid", rx_valid_o, 0);
    checkOutput("rst.rxData", rx_data_o, 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Three buffered bytes, loopback into RX
    sentQ.delete(); rxQ.delete();
    doneBase = doneCount; csBase = csRiseCount;
    pushTx(8'hA5); pushTx(8'h3C); pushTx(8'hF0);
    applyStimulus(8'd3);
    checkOutput("t1.busy", busy_o, 1);
    waitIdle("t1");
    checkBytes("t1.sent", sentQ, 64'hA53CF0, 3);
    checkBytes("t1.rx", rxQ, 64'hA53CF0, 3);
    checkOutput("t1.csRises", csRiseCount - csBase, 1);
    checkOutput("t1.donePulses", doneCount - doneBase, 1);
    checkOutput("t1.underrun", tx_underrun_o, 0);
    checkOutput("t1.overflow", rx_overflow_o, 0);

    // TX underrun: fill bytes substituted
    sentQ.delete(); rxQ.delete();
    doneBase = doneCount;
    pushTx(8'h11);
    applyStimulus(8'd3);
    waitIdle("t2");
    checkBytes("t2.sent", sentQ, 64'h11FFFF, 3);
    checkBytes("t2.rx", rxQ, 64'h11FFFF, 3);
    checkOutput("t2.underrun", tx_underrun_o, 1);
    checkOutput("t2.donePulses", doneCount - doneBase, 1);

    // RX overflow with no host pops (RX depth 2); underrun cleared by the new start
    sentQ.delete(); rxQ.delete();
    doneBase = doneCount;
    rx_ready_i = 1'b0;
    pushTx(8'h01); pushTx(8'h02); pushTx(8'h03); pushTx(8'h04);
    applyStimulus(8'd4);
    waitIdle("t3");
    checkBytes("t3.sent", sentQ, 64'h01020304, 4);
    checkOutput("t3.overflow", rx_overflow_o, 1);
    checkOutput("t3.underrun", tx_underrun_o, 0);
    checkOutput("t3.donePulses", doneCount - doneBase, 1);
    checkOutput("t3.rxValid", rx_valid_o, 1);
    checkOutput("t3.rxHead", rx_data_o, 8'h01);
    rx_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    checkBytes("t3.rx", rxQ, 64'h0102, 2);

    // Zero-length start is a no-op
    doneBase = doneCount;
    sawBusy  = 1'b0;
    applyStimulus(8'd0);
    for (int i = 0; i < 6; i++) begin
      sawBusy |= busy_o;
      @(negedge clk_i);
    end
    checkOutput("t4.busy", sawBusy, 0);
    checkOutput("t4.donePulses", doneCount - doneBase, 0);
    checkOutput("t4.overflow", rx_overflow_o, 1);

    // Start during RUN is ignored
    sentQ.delete(); rxQ.delete();
    doneBase = doneCount;
    pushTx(8'hAA); pushTx(8'hBB);
    applyStimulus(8'd2);
    repeat (10) @(negedge clk_i);
    checkOutput("t5.busyMid", busy_o, 1);
    applyStimulus(8'd5);
    waitIdle("t5");
    checkBytes("t5.sent", sentQ, 64'hAABB, 2);
    checkBytes("t5.rx", rxQ, 64'hAABB, 2);
    checkOutput("t5.donePulses", doneCount - doneBase, 1);
    checkOutput("t5.overflow", rx_overflow_o, 0);

    // Reset during byte 2 of a five-byte transaction
    sentQ.delete(); rxQ.delete();
    pushTx(8'h21); pushTx(8'h22); pushTx(8'h23); pushTx(8'h24); pushTx(8'h25);
    applyStimulus(8'd5);
    for (int i = 0; i < 500 && sentQ.size() < 2; i++) @(negedge clk_i);
    checkOutput("t6.byte2Started", sentQ.size(), 2);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("t6.en", spi_en_o, 0);
    checkOutput("t6.busy", busy_o, 0);
    checkOutput("t6.txReady", tx_ready_o, 1);
    checkOutput("t6.rxValid", rx_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    sentQ.delete(); rxQ.delete();
    doneBase = doneCount;
    pushTx(8'h66);
    applyStimulus(8'd2);
    waitIdle("t6");
    checkBytes("t6.sent", sentQ, 64'h66FF, 2);
    checkBytes("t6.rx", rxQ, 64'h66FF, 2);
    checkOutput("t6.underrun", tx_underrun_o, 1);
    checkOutput("t6.donePulses", doneCount - doneBase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
